// File: rtl/spill_stack.sv
// LIFO operand stack: a DEPTH-entry register cache whose oldest entries spill to a
// memory-backed area when the cache is full and are filled back when it runs empty.
module spill_stack #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int BASE_ADDR   = 0,
  parameter int MEM_ENTRIES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      insert,
  output logic [WIDTH-1:0]      top,
  output logic                  push_ready,
  output logic                  pop_ready,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  mem_re,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ack
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(MEM_ENTRIES + 1);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0]      PTR_FULL = PTR_W'(MEM_ENTRIES);
  localparam logic [ADDR_WIDTH-1:0] LP_BASE  = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {ST_IDLE, ST_SPILL, ST_FILL} state_t;

  state_t                  r_state, w_state_n;
  logic [WIDTH-1:0]        r_cache [DEPTH];
  logic [CNT_W-1:0]        r_cnt;
  logic [PTR_W-1:0]        r_mem_ptr;
  logic                    r_mem_we, r_mem_re;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [WIDTH-1:0]        r_mem_wdata;
  logic                    r_overflow, r_underflow;

  logic                    w_idle, w_push_acc, w_pop_acc;
  logic                    w_spill_done, w_fill_done;
  logic [IDX_W-1:0]        w_top_idx, w_push_idx;
  logic [ADDR_WIDTH-1:0]   w_spill_addr, w_fill_addr;

  assign w_idle       = (r_state == ST_IDLE);
  assign push_ready   = w_idle && (r_cnt < CNT_FULL);
  assign pop_ready    = w_idle && (r_cnt != '0);
  assign w_push_acc   = push && push_ready;
  assign w_pop_acc    = pop && pop_ready;
  assign w_spill_done = (r_state == ST_SPILL) && r_mem_we && mem_ack;
  assign w_fill_done  = (r_state == ST_FILL) && r_mem_re && mem_ack;

  assign w_top_idx    = IDX_W'(r_cnt - CNT_ONE);
  assign w_push_idx   = IDX_W'(r_cnt);
  assign w_spill_addr = LP_BASE + ADDR_WIDTH'(r_mem_ptr);
  assign w_fill_addr  = LP_BASE + ADDR_WIDTH'(r_mem_ptr) - ADDR_WIDTH'(1);

  assign top       = (r_cnt != '0) ? r_cache[w_top_idx] : '0;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign mem_re    = r_mem_re;

  // NOTE: next state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_cnt == CNT_FULL && r_mem_ptr != PTR_FULL && !w_pop_acc) w_state_n = ST_SPILL;
        else if (r_cnt == '0 && r_mem_ptr != '0)                       w_state_n = ST_FILL;
      end
      ST_SPILL: if (w_spill_done) w_state_n = ST_IDLE;
      ST_FILL:  if (w_fill_done)  w_state_n = ST_IDLE;
      default:  w_state_n = ST_IDLE;
    endcase
  end

  // NOTE: the cache is plain storage with no reset; r_cnt alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_cache[w_pop_acc ? w_top_idx : w_push_idx] <= insert;
    end else if (w_spill_done) begin
      for (int i = 0; i < DEPTH - 1; i++) r_cache[i] <= r_cache[i+1];
    end else if (w_fill_done) begin
      r_cache[0] <= mem_rdata;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_mem_ptr   <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state <= w_state_n;

      if (w_push_acc && !w_pop_acc)      r_cnt <= r_cnt + CNT_ONE;
      else if (w_pop_acc && !w_push_acc) r_cnt <= r_cnt - CNT_ONE;
      else if (w_spill_done)             r_cnt <= r_cnt - CNT_ONE;
      else if (w_fill_done)              r_cnt <= CNT_ONE;

      if (w_spill_done)     r_mem_ptr <= r_mem_ptr + PTR_ONE;
      else if (w_fill_done) r_mem_ptr <= r_mem_ptr - PTR_ONE;

      // Requests launch one cycle into SPILL/FILL and stay frozen until acknowledged.
      if (r_state == ST_SPILL && !r_mem_we) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= w_spill_addr;
        r_mem_wdata <= r_cache[0];
      end else if (r_state == ST_FILL && !r_mem_re) begin
        r_mem_re   <= 1'b1;
        r_mem_addr <= w_fill_addr;
      end else if (w_spill_done || w_fill_done) begin
        r_mem_we <= 1'b0;
        r_mem_re <= 1'b0;
      end

      if (push && r_cnt == CNT_FULL && r_mem_ptr == PTR_FULL) r_overflow  <= 1'b1;
      if (pop && r_cnt == '0 && r_mem_ptr == '0)              r_underflow <= 1'b1;
    end
  end

endmodule

// File: doc/spill_stack.md
Name: spill_stack

Overview:
- LIFO operand stack with a DEPTH-entry register cache in front of a memory-backed spill area.
- When the cache fills, the bottom entry is written out (spilled) to memory.
- When the cache empties and spilled entries exist, the newest spilled entry is read back (filled) to the bottom of the cache.
- Sits between the core's push/pop datapath and a single-port data-memory arbiter, giving the core an effectively unbounded stack with per-direction ready signals.

Parameters:
- WIDTH, 32, data width of each stack entry.
- DEPTH, 8, number of cache entries held in registers (at least 2).
- ADDR_WIDTH, 16, memory address width.
- BASE_ADDR, 0, address of spill slot 0.
- MEM_ENTRIES, 256, maximum number of spilled entries (at most 2^ADDR_WIDTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  push request; takes effect only when push_ready=1.
- pop  in  1  pop request; takes effect only when pop_ready=1.
- insert  in  WIDTH  value to push.
- top  out  WIDTH  current top-of-stack; 0 when the cache is empty.
- push_ready  out  1  push accepted this cycle if asserted.
- pop_ready  out  1  pop accepted this cycle if asserted.
- overflow  out  1  sticky: push attempted with cache full and spill area full.
- underflow  out  1  sticky: pop attempted with cache empty and spill area empty.
- mem_addr  out  ADDR_WIDTH  spill/fill address.
- mem_we  out  1  write request; held until mem_ack.
- mem_wdata  out  WIDTH  spill data.
- mem_re  out  1  read request; held until mem_ack.
- mem_rdata  in  WIDTH  fill data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion of the outstanding request.

Behaviour:
- State: cnt (0..DEPTH, cache occupancy), mem_ptr (0..MEM_ENTRIES, spilled count), FSM state in {IDLE, SPILL, FILL}.
- Cache ordering: entry 0 is the oldest, entry cnt-1 is the top. top = cache[cnt-1] when cnt>0, else 0. top is a combinational function of registered state.
- Ready signals:
  - push_ready = IDLE and cnt<DEPTH.
  - pop_ready = IDLE and cnt>0.
  - Both are 0 in SPILL and FILL.
- Accepted operations in IDLE:
  - push only: cache[cnt] <= insert; cnt+1.
  - pop only: cnt-1.
  - push and pop together with cnt>0: cache[cnt-1] <= insert (top replaced); cnt unchanged.
  - Requests that are not ready are ignored. Exceptions: push with cnt==DEPTH and mem_ptr==MEM_ENTRIES sets overflow; pop with cnt==0 and mem_ptr==0 sets underflow.
- IDLE -> SPILL: when cnt==DEPTH, mem_ptr<MEM_ENTRIES, and no pop is accepted this cycle.
  - In SPILL: mem_we=1, mem_addr=BASE_ADDR+mem_ptr, mem_wdata=cache[0].
  - On mem_ack: shift cache down one slot, cnt-1, mem_ptr+1, go to IDLE.
- IDLE -> FILL: when cnt==0 and mem_ptr>0.
  - In FILL: mem_re=1, mem_addr=BASE_ADDR+mem_ptr-1.
  - On mem_ack: cache[0] <= mem_rdata, cnt=1, mem_ptr-1, go to IDLE.
- Memory request signals are registered. They assert in the cycle after entering SPILL/FILL, are held constant until mem_ack, and drop in the cycle after ack. mem_we and mem_re are never high together.
- Latency: push/pop take effect at the next edge. A spill or fill costs 2 + (memory wait) cycles of not-ready.
- mem_ack in IDLE is ignored.
- Reset (overrides everything, including mid-SPILL/FILL):
  - cnt=0, mem_ptr=0, IDLE, mem_we=mem_re=0, mem_addr=0, mem_wdata=0, overflow=underflow=0.
  - Resulting outputs: top=0, push_ready=1, pop_ready=0.
  - An outstanding memory request is abandoned.
- overflow and underflow clear only on reset.

Test Plan:
- Push 0..7 (DEPTH=8), then pop 8 times with no memory activity -> top reads 7,6,...,0; pop_ready=0 after the last pop; mem_we never asserted.
- Push 0..8 with a memory model acking 1 cycle after request:
  - After the 8th push, a SPILL writes 0 to BASE_ADDR; cnt=7, mem_ptr=1.
  - Push 8 is then accepted; top=8.
- Continue from the previous scenario and pop 9 times:
  - After popping 1, a FILL reads BASE_ADDR and top=0.
  - One more pop empties the stack; no spurious FILL follows.
- With cnt=3 and top=5, assert push+pop with insert=9 -> top=9, cnt stays 3. With cnt=0, pop -> underflow=1 and stays 1.
- Fill the cache with MEM_ENTRIES=1 and mem_ptr=1, then push -> push_ready=0, overflow=1, no mem_we.
- Assert reset during SPILL before ack -> next cycle mem_we=0, push_ready=1, pop_ready=0, top=0; a late mem_ack is ignored.
